// File: rtl/aud_dsp_player.sv
// Purpose: audio playback engine that fetches SRAM samples on each DAC LR-clock rise and plays them at normal, fast (x N), slow-hold or slow-linear speed.
// Latency: 4-5 i_clk cycles from a raw i_daclrck rise to o_dac_valid (2 sync, 1 detect, FETCH, CALC).
// Backpressure: none; the LR clock paces the engine, and any LR edge that arrives outside WAIT is dropped.
//
// Ports: i_clk/i_rst_n (async active-low reset); i_start/i_pause/i_stop control pulses;
//        i_mode/i_speed set the playback mode and factor N = i_speed+1; i_reverse sets direction;
//        i_daclrck is the async LR clock; i_start_addr/i_end_addr give the inclusive window;
//        o_sram_addr/i_sram_data form the SRAM read port (1-cycle latency);
//        o_dac_data/o_dac_valid carry the sample stream; o_busy and o_done report status.
// Build option: define AUD_DSP_REVERSE_EN to honour i_reverse, which is sampled at start.
//               Without it, playback always runs forward.
module aud_dsp_player #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 20,
    parameter int SPEED_W = 3,
    parameter int RECIP_W = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic               i_pause,
    input  logic               i_stop,
    input  logic [1:0]         i_mode,
    input  logic [SPEED_W-1:0] i_speed,
    input  logic               i_reverse,
    input  logic               i_daclrck,
    input  logic [ADDR_W-1:0]  i_start_addr,
    input  logic [ADDR_W-1:0]  i_end_addr,
    output logic [ADDR_W-1:0]  o_sram_addr,
    input  logic [DATA_W-1:0]  i_sram_data,
    output logic [DATA_W-1:0]  o_dac_data,
    output logic               o_dac_valid,
    output logic               o_busy,
    output logic               o_done
);
    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_FETCH, S_CALC, S_PAUSE} state_t;

    localparam int NW = SPEED_W + 1;                          // holds N up to 2^SPEED_W
    localparam int PW = DATA_W + SPEED_W + RECIP_W + 2;       // interpolation product width
    localparam logic signed [PW-1:0] HALF    = {{(PW-RECIP_W){1'b0}}, 1'b1, {(RECIP_W-1){1'b0}}};
    localparam logic signed [PW-1:0] SAT_MAX = {{(PW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_MIN = ~SAT_MAX;

    state_t                    state;
    logic                      lr_s1, lr_s2, lr_prev;
    logic [ADDR_W-1:0]         win_lo, win_hi;
    logic [SPEED_W-1:0]        count;
    logic signed [DATA_W-1:0]  prev;
    logic [1:0]                last_mode;
    logic [SPEED_W-1:0]        last_speed;
    logic                      rev_q;
    logic                      pause_pend;
    logic                      start_rev;

`ifdef AUD_DSP_REVERSE_EN
    assign start_rev = i_reverse;
`else
    logic unused_rev;
    assign start_rev  = 1'b0;
    assign unused_rev = i_reverse;
`endif

    // Rising edge of the synchronised LR clock
    logic lr_edge;
    assign lr_edge = lr_s2 & ~lr_prev;

    // Reciprocal table R[N] = round(2^RECIP_W / N), indexed by i_speed (N-1)
    logic [RECIP_W:0] recip_lut [2**SPEED_W];
    for (genvar g = 0; g < 2**SPEED_W; g++) begin : g_recip
        localparam longint unsigned RV = ((64'd1 << RECIP_W) + longint'((g + 1) / 2)) / longint'(g + 1);
        assign recip_lut[g] = (RECIP_W+1)'(RV);
    end

    // Per-CALC decode. A mode or speed change since the previous CALC restarts the group at k=0.
    logic [1:0]         mode_n;
    logic               cfg_chg;
    logic [SPEED_W-1:0] k;
    logic               grp_end;
    logic [NW-1:0]      n_fac, step;
    logic [ADDR_W:0]    addr_w, step_x, fwd, rev;
    logic [ADDR_W-1:0]  next_addr;
    logic               at_end;

    assign mode_n  = (i_mode == 2'd3) ? 2'd0 : i_mode;
    assign cfg_chg = (mode_n != last_mode) || (i_speed != last_speed);
    assign k       = cfg_chg ? '0 : count;
    assign grp_end = (k == i_speed);
    assign n_fac   = {1'b0, i_speed} + NW'(1);
    assign step    = (mode_n == 2'd0) ? n_fac : NW'(1);

    // The extra top bit catches wrap past either end of the address space
    assign addr_w = {1'b0, o_sram_addr};
    assign step_x = {{(ADDR_W+1-NW){1'b0}}, step};
    assign fwd    = addr_w + step_x;
    assign rev    = addr_w - step_x;
    always_comb begin
        next_addr = fwd[ADDR_W-1:0];
        if (rev_q) begin
            next_addr = (rev[ADDR_W] || (rev < {1'b0, win_lo})) ? win_lo : rev[ADDR_W-1:0];
        end else if (fwd > {1'b0, win_hi}) begin
            next_addr = win_hi;
        end
    end
    assign at_end = rev_q ? (o_sram_addr == win_lo) : (o_sram_addr == win_hi);

    // Linear interpolation: ((N-k)*prev + k*cur) * R[N], rounded, then saturated
    logic signed [PW-1:0]     prev_x, cur_x, wa_x, wb_x, r_x, mix, prod, rnd;
    logic signed [DATA_W-1:0] interp, calc_out;

    assign prev_x = {{(PW-DATA_W){prev[DATA_W-1]}}, prev};
    assign cur_x  = {{(PW-DATA_W){i_sram_data[DATA_W-1]}}, i_sram_data};
    assign wa_x   = {{(PW-NW){1'b0}}, n_fac - {1'b0, k}};
    assign wb_x   = {{(PW-NW){1'b0}}, 1'b0, k};
    assign r_x    = {{(PW-RECIP_W-1){1'b0}}, recip_lut[i_speed]};
    assign mix    = wa_x * prev_x + wb_x * cur_x;
    assign prod   = mix * r_x;
    assign rnd    = (prod + HALF) >>> RECIP_W;
    always_comb begin
        interp = rnd[DATA_W-1:0];
        if (rnd > SAT_MAX)      interp = SAT_MAX[DATA_W-1:0];
        else if (rnd < SAT_MIN) interp = SAT_MIN[DATA_W-1:0];
    end
    assign calc_out = (mode_n == 2'd2) ? interp : i_sram_data;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= S_IDLE;
            lr_s1       <= 1'b0;
            lr_s2       <= 1'b0;
            lr_prev     <= 1'b0;
            win_lo      <= '0;
            win_hi      <= '0;
            count       <= '0;
            prev        <= '0;
            last_mode   <= '0;
            last_speed  <= '0;
            rev_q       <= 1'b0;
            pause_pend  <= 1'b0;
            o_sram_addr <= '0;
            o_dac_data  <= '0;
            o_dac_valid <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            lr_s1       <= i_daclrck;
            lr_s2       <= lr_s1;
            lr_prev     <= lr_s2;
            o_dac_valid <= 1'b0;
            o_done      <= 1'b0;
            if (i_stop) begin
                state      <= S_IDLE;
                o_busy     <= 1'b0;
                o_dac_data <= '0;
                count      <= '0;
                prev       <= '0;
                pause_pend <= 1'b0;
            end else if (i_start && state != S_PAUSE) begin
                // Start from IDLE, or restart from the window start while playing
                pause_pend <= 1'b0;
                if (i_end_addr < i_start_addr) begin
                    state  <= S_IDLE;
                    o_busy <= 1'b0;
                    o_done <= 1'b1;
                end else begin
                    state       <= S_WAIT;
                    o_busy      <= 1'b1;
                    win_lo      <= i_start_addr;
                    win_hi      <= i_end_addr;
                    rev_q       <= start_rev;
                    o_sram_addr <= start_rev ? i_end_addr : i_start_addr;
                    count       <= '0;
                    prev        <= '0;
                    last_mode   <= mode_n;
                    last_speed  <= i_speed;
                end
            end else begin
                case (state)
                    S_WAIT: begin
                        if (i_pause || pause_pend) begin
                            state      <= S_PAUSE;
                            pause_pend <= 1'b0;
                        end else if (lr_edge) begin
                            state <= S_FETCH;
                        end
                    end
                    S_FETCH: begin
                        pause_pend <= pause_pend | i_pause;
                        state      <= S_CALC;
                    end
                    S_CALC: begin
                        o_dac_data  <= calc_out;
                        o_dac_valid <= 1'b1;
                        last_mode   <= mode_n;
                        last_speed  <= i_speed;
                        pause_pend  <= pause_pend | i_pause;
                        state       <= S_WAIT;
                        if (mode_n == 2'd0 || grp_end) begin
                            count <= '0;
                            if (mode_n == 2'd2) prev <= i_sram_data;
                            if (at_end) begin
                                state      <= S_IDLE;
                                o_busy     <= 1'b0;
                                o_done     <= 1'b1;
                                pause_pend <= 1'b0;
                            end else begin
                                o_sram_addr <= next_addr;
                            end
                        end else begin
                            count <= k + 1'b1;
                        end
                    end
                    S_PAUSE: begin
                        if (i_start) state <= S_WAIT;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
